// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line engine and its CRC7 helper.
package sd_cmd_pkg;

    localparam int CMD_BITS        = 48;
    localparam int RESP_SHORT_BITS = 48;
    localparam int RESP_LONG_BITS  = 136;
    localparam int CRC_BITS        = 7;
    localparam int LONG_HDR_BITS   = 8;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        SHORT       = 2'd1,
        LONG        = 2'd2,
        SHORT_NOCRC = 2'd3
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_RESP_WAIT,
        ST_RECV,
        ST_BUSY_WAIT,
        ST_NCC
    } state_t;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
    function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] crc,
                                                      input logic b);
        logic fb;
        fb = b ^ crc[CRC_BITS-1];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

endpackage

// File: rtl/sd_crc_7.sv
// Serial CRC7 accumulator with synchronous clear; shared by the command and response paths.
module sd_crc_7
    import sd_cmd_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_clr,
    input  logic                i_shift,
    input  logic                i_bit,
    output logic [CRC_BITS-1:0] o_crc
);

    logic [CRC_BITS-1:0] r_crc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= '0;
        end else if (i_shift) begin
            r_crc <= crc7_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command and receives none/short/long/no-CRC responses.
// Optional R1b busy wait on DAT0 is built when SD_CMD_BUSY_EN is defined.
module sd_cmd_engine
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_W       = 16,
    parameter int DEFAULT_TIMEOUT = 64,
    parameter int NCC_BITS        = 8,
    parameter int BUSY_TIMEOUT_W  = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_sd_clk_rising,
    input  logic                 i_sd_clk_falling,
    input  logic                 i_sd_cmd,
    output logic                 o_sd_cmd,
    output logic                 o_sd_cmd_oe,
    input  logic                 i_sd_dat0,
    input  logic [5:0]           i_cmd_index,
    input  logic [31:0]          i_cmd_arg,
    input  logic [1:0]           i_resp_type,
    input  logic                 i_resp_busy,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [5:0]           o_resp_index,
    output logic [127:0]         o_resp,
    output logic                 o_timeout,
    output logic                 o_crc_error,
    output logic                 o_index_error,
    output logic                 o_end_bit_error,
    output logic                 o_busy_timeout
);

    localparam logic [7:0] SEND_LAST      = 8'(CMD_BITS - 1);
    localparam logic [7:0] SEND_CRC_START = 8'(CMD_BITS - CRC_BITS - 1);

    state_t              r_state;
    resp_type_t          r_type;
    logic                r_pending, r_sd_cmd, r_sd_cmd_oe, r_done;
    logic                r_timeout, r_crc_error, r_index_error, r_end_bit_error;
    logic [5:0]          r_index, r_resp_index;
    logic [31:0]         r_arg;
    logic [127:0]        r_resp;
    logic [TIMEOUT_W-1:0] r_timeout_lim, r_wait_cnt;
    logic [7:0]          r_bit_cnt;
    logic [134:0]        r_rx_sr;

    logic                w_busy, w_long, w_rx_cover, w_send_bit;
    logic                w_crc_clr, w_crc_shift, w_crc_in, w_start_take;
    logic [CRC_BITS-1:0] w_crc;
    logic [39:0]         w_frame;
    logic [7:0]          w_next_cnt, w_rx_k, w_rx_last;
    logic [5:0]          w_frame_idx;
    logic [2:0]          w_crc_idx;
    logic [135:0]        w_rx_full;

    assign w_busy       = r_pending || (r_state != ST_IDLE);
    assign w_long       = (r_type == LONG);
    assign w_frame      = {2'b01, r_index, r_arg};
    assign w_next_cnt   = r_bit_cnt + 8'd1;
    assign w_frame_idx  = 6'(SEND_CRC_START - 8'd1 - w_next_cnt);
    assign w_crc_idx    = 3'(SEND_LAST - 8'd1 - w_next_cnt);
    assign w_rx_full    = {r_rx_sr, i_sd_cmd};
    assign w_rx_k       = (r_state == ST_RECV) ? r_bit_cnt : 8'd0;
    assign w_rx_last    = w_long ? 8'(RESP_LONG_BITS - 1) : 8'(RESP_SHORT_BITS - 1);
    assign w_start_take = (r_state == ST_IDLE) && r_pending && i_sd_clk_falling;

    // CRC field is folded into the running CRC, so a good response leaves a zero residue.
    assign w_rx_cover = w_long ? ((w_rx_k >= 8'(LONG_HDR_BITS)) && (w_rx_k <= 8'(RESP_LONG_BITS - 2)))
                               : (w_rx_k <= 8'(RESP_SHORT_BITS - 2));

    always_comb begin
        w_send_bit = 1'b1;
        if (w_next_cnt < SEND_CRC_START)
            w_send_bit = w_frame[w_frame_idx];
        else if (w_next_cnt < SEND_LAST)
            w_send_bit = w_crc[w_crc_idx];
    end

    assign w_crc_clr   = w_start_take ||
                         ((r_state == ST_SEND) && i_sd_clk_falling && (r_bit_cnt == SEND_LAST));
    assign w_crc_in    = (r_state == ST_SEND) ? r_sd_cmd : i_sd_cmd;
    assign w_crc_shift = i_sd_clk_rising &&
                         (((r_state == ST_SEND) && (r_bit_cnt < SEND_CRC_START)) ||
                          ((r_state == ST_RESP_WAIT) && !i_sd_cmd && w_rx_cover) ||
                          ((r_state == ST_RECV) && w_rx_cover));

    sd_crc_7 u_crc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (w_crc_clr),
        .i_shift   (w_crc_shift),
        .i_bit     (w_crc_in),
        .o_crc     (w_crc)
    );

`ifdef SD_CMD_BUSY_EN
    logic                      r_resp_busy, r_busy_timeout;
    logic [1:0]                r_busy_skip;
    logic [BUSY_TIMEOUT_W-1:0] r_busy_cnt;
    assign o_busy_timeout = r_busy_timeout;
`else
    logic w_unused;
    assign w_unused       = i_sd_dat0 ^ i_resp_busy ^ (BUSY_TIMEOUT_W > 0);
    assign o_busy_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ST_IDLE;
            r_type          <= NONE;
            r_pending       <= 1'b0;
            r_sd_cmd        <= 1'b1;
            r_sd_cmd_oe     <= 1'b0;
            r_done          <= 1'b0;
            r_timeout       <= 1'b0;
            r_crc_error     <= 1'b0;
            r_index_error   <= 1'b0;
            r_end_bit_error <= 1'b0;
            r_index         <= '0;
            r_resp_index    <= '0;
            r_arg           <= '0;
            r_resp          <= '0;
            r_timeout_lim   <= '0;
            r_wait_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_rx_sr         <= '0;
`ifdef SD_CMD_BUSY_EN
            r_resp_busy     <= 1'b0;
            r_busy_timeout  <= 1'b0;
            r_busy_skip     <= '0;
            r_busy_cnt      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (i_start && !w_busy)
                r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_start_take) begin
                    r_pending       <= 1'b0;
                    r_index         <= i_cmd_index;
                    r_arg           <= i_cmd_arg;
                    r_type          <= resp_type_t'(i_resp_type);
                    r_timeout_lim   <= (i_timeout == '0) ? TIMEOUT_W'(DEFAULT_TIMEOUT) : i_timeout;
                    r_timeout       <= 1'b0;
                    r_crc_error     <= 1'b0;
                    r_index_error   <= 1'b0;
                    r_end_bit_error <= 1'b0;
                    r_resp          <= '0;
                    r_sd_cmd        <= 1'b0;
                    r_sd_cmd_oe     <= 1'b1;
                    r_bit_cnt       <= '0;
                    r_state         <= ST_SEND;
`ifdef SD_CMD_BUSY_EN
                    r_resp_busy     <= i_resp_busy;
                    r_busy_timeout  <= 1'b0;
`endif
                end
                ST_SEND: if (i_sd_clk_falling) begin
                    if (r_bit_cnt == SEND_LAST) begin
                        r_sd_cmd    <= 1'b1;
                        r_sd_cmd_oe <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_wait_cnt  <= '0;
                        r_state     <= (r_type == NONE) ? ST_NCC : ST_RESP_WAIT;
                    end else begin
                        r_bit_cnt <= w_next_cnt;
                        r_sd_cmd  <= w_send_bit;
                    end
                end
                ST_RESP_WAIT: if (i_sd_clk_rising) begin
                    if (!i_sd_cmd) begin
                        r_rx_sr   <= w_rx_full[134:0];
                        r_bit_cnt <= 8'd1;
                        r_state   <= ST_RECV;
                    end else if (TIMEOUT_W'(r_wait_cnt + 1'b1) == r_timeout_lim) begin
                        r_timeout <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_NCC;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RECV: if (i_sd_clk_rising) begin
                    r_rx_sr <= w_rx_full[134:0];
                    if (r_bit_cnt == w_rx_last) begin
                        if (w_long) begin
                            r_resp       <= {w_rx_full[127:1], 1'b0};
                            r_resp_index <= w_rx_full[133:128];
                        end else begin
                            r_resp       <= {96'd0, w_rx_full[39:8]};
                            r_resp_index <= w_rx_full[45:40];
                        end
                        r_crc_error     <= (r_type != SHORT_NOCRC) && (w_crc != '0);
                        r_index_error   <= (r_type == SHORT) && (w_rx_full[45:40] != r_index);
                        r_end_bit_error <= !i_sd_cmd;
                        r_bit_cnt       <= '0;
`ifdef SD_CMD_BUSY_EN
                        r_busy_skip     <= '0;
                        r_busy_cnt      <= '0;
                        r_state         <= r_resp_busy ? ST_BUSY_WAIT : ST_NCC;
`else
                        r_state         <= ST_NCC;
`endif
                    end else begin
                        r_bit_cnt <= w_next_cnt;
                    end
                end
`ifdef SD_CMD_BUSY_EN
                ST_BUSY_WAIT: if (i_sd_clk_rising) begin
                    // The first two strobes after the end bit belong to the card's turnaround.
                    if (r_busy_skip != 2'd2) begin
                        r_busy_skip <= r_busy_skip + 2'd1;
                    end else if (i_sd_dat0) begin
                        r_state <= ST_NCC;
                    end else if (BUSY_TIMEOUT_W'(r_busy_cnt + 1'b1) == '1) begin
                        r_busy_timeout <= 1'b1;
                        r_state        <= ST_NCC;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + 1'b1;
                    end
                end
`endif
                ST_NCC: if (i_sd_clk_rising) begin
                    if (r_bit_cnt == 8'(NCC_BITS - 1)) begin
                        r_bit_cnt <= '0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_bit_cnt <= w_next_cnt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sd_cmd        = r_sd_cmd;
    assign o_sd_cmd_oe     = r_sd_cmd_oe;
    assign o_busy          = w_busy;
    assign o_done          = r_done;
    assign o_resp_index    = r_resp_index;
    assign o_resp          = r_resp;
    assign o_timeout       = r_timeout;
    assign o_crc_error     = r_crc_error;
    assign o_index_error   = r_index_error;
    assign o_end_bit_error = r_end_bit_error;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed cases plus randomized commands against a reference model.
module tb_sd_cmd_engine;

    logic clk = 1'b0;
    logic rst_n, rise, fall, sd_cmd_in, sd_dat0, start, resp_busy;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    logic [15:0]  tmo;
    logic o_sd_cmd, o_sd_cmd_oe, o_busy, o_done, o_timeout;
    logic o_crc_error, o_index_error, o_end_bit_error, o_busy_timeout;
    logic [5:0]   o_resp_index;
    logic [127:0] o_resp;

    int checks = 0;
    int errors = 0;
    int ph = 0;
    logic [47:0] frame_cap;
    int oe_bits, rises_low, rises_at_tmo, done_cyc;
    bit done_seen;

    always #5 clk = ~clk;

    sd_cmd_engine dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_sd_clk_rising(rise), .i_sd_clk_falling(fall),
        .i_sd_cmd(sd_cmd_in), .o_sd_cmd(o_sd_cmd), .o_sd_cmd_oe(o_sd_cmd_oe),
        .i_sd_dat0(sd_dat0),
        .i_cmd_index(idx), .i_cmd_arg(arg), .i_resp_type(rtype), .i_resp_busy(resp_busy),
        .i_timeout(tmo), .i_start(start),
        .o_busy(o_busy), .o_done(o_done), .o_resp_index(o_resp_index), .o_resp(o_resp),
        .o_timeout(o_timeout), .o_crc_error(o_crc_error), .o_index_error(o_index_error),
        .o_end_bit_error(o_end_bit_error), .o_busy_timeout(o_busy_timeout)
    );

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // SD clock = clk/4; strobes change on the negative clk edge, DUT samples on the positive one.
    task automatic tick();
        @(negedge clk);
        ph   = (ph + 1) % 4;
        rise = (ph == 0);
        fall = (ph == 2);
    endtask

    // Textbook CRC7 by long division of the low n bits of d, augmented by seven zeros.
    function automatic logic [6:0] crc7_div(input logic [135:0] d, input int n);
        logic [7:0] r;
        r = 8'd0;
        for (int i = n - 1; i >= -7; i--) begin
            r = {r[6:0], (i >= 0) ? d[i] : 1'b0};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic run_cmd(input logic [5:0] c_idx, input logic [31:0] c_arg, input logic [1:0] c_type,
                           input logic [15:0] c_tmo, input logic [135:0] c_resp, input int c_len,
                           input int c_ncr, input int poke_at, input int abort_at, input int dat0_low);
        int  falls_low, dev_pos, after_cnt;
        bit  host_done, aborted;
        idx = c_idx; arg = c_arg; rtype = c_type; tmo = c_tmo;
        sd_dat0 = (dat0_low > 0) ? 1'b0 : 1'b1;
        frame_cap = '0; oe_bits = 0; rises_low = 0; rises_at_tmo = -1; done_seen = 0; done_cyc = 0;
        falls_low = 0; dev_pos = 0; after_cnt = 0; aborted = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 136'(o_busy), 136'(1));
        for (int cyc = 0; cyc < 20000; cyc++) begin
            tick();
            start = 1'b0;
            if (o_done) begin
                done_seen = 1;
                done_cyc  = cyc;
                break;
            end
            if (o_timeout && rises_at_tmo < 0) rises_at_tmo = rises_low;
            host_done = (oe_bits == 48) && !o_sd_cmd_oe;
            if (rise && o_sd_cmd_oe) begin
                frame_cap = {frame_cap[46:0], o_sd_cmd};
                oe_bits++;
                if (oe_bits == poke_at) begin
                    idx = ~c_idx; arg = ~c_arg; start = 1'b1;
                end
            end
            if (rise && host_done) rises_low++;
            if (fall && host_done && c_len > 0) begin
                falls_low++;
                if (falls_low >= c_ncr) begin
                    if (dev_pos < c_len) begin
                        sd_cmd_in = c_resp[c_len - 1 - dev_pos];
                        dev_pos++;
                    end else begin
                        sd_cmd_in = 1'b1;
                    end
                end
            end
            if (c_len > 0 && dev_pos >= c_len) begin
                sd_dat0 = (after_cnt < dat0_low) ? 1'b0 : 1'b1;
                after_cnt++;
            end
            if (abort_at > 0 && dev_pos == abort_at && rise) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 136'(o_busy), 136'(0));
                check("abort_oe", 136'(o_sd_cmd_oe), 136'(0));
                check("abort_resp", 136'(o_resp), 136'(0));
                tick();
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        sd_cmd_in = 1'b1;
        sd_dat0   = 1'b1;
        if (!aborted) check("done_seen", 136'(done_seen), 136'(1));
        $display("cmd idx=%0d type=%0d frame=%h resp=%h ridx=%0d tmo=%0d crc=%0d ierr=%0d eerr=%0d cyc=%0d abort=%0d",
                 c_idx, c_type, frame_cap, o_resp, o_resp_index, o_timeout, o_crc_error,
                 o_index_error, o_end_bit_error, done_cyc, aborted);
    endtask

    task automatic check_model(input logic [5:0] c_idx, input logic [31:0] c_arg, input logic [1:0] c_type,
                               input logic [135:0] c_resp, input int c_len);
        logic [47:0]  ef;
        logic [127:0] e_resp;
        logic [5:0]   e_ri;
        logic e_t, e_c, e_i, e_e;
        bit   chk_ri;
        ef = {2'b01, c_idx, c_arg, crc7_div(136'({2'b01, c_idx, c_arg}), 40), 1'b1};
        e_resp = '0; e_ri = 6'd0; e_t = 0; e_c = 0; e_i = 0; e_e = 0; chk_ri = 0;
        if (c_type != 2'd0 && c_len == 0) begin
            e_t = 1;
        end else if (c_type == 2'd2) begin
            e_resp = {c_resp[127:1], 1'b0};
            e_ri   = c_resp[133:128];
            e_c    = crc7_div(136'(c_resp[127:8]), 120) != c_resp[7:1];
            e_e    = !c_resp[0];
            chk_ri = 1;
        end else if (c_type != 2'd0) begin
            e_resp = {96'd0, c_resp[39:8]};
            e_ri   = c_resp[45:40];
            e_c    = (c_type == 2'd1) && (crc7_div(136'(c_resp[47:8]), 40) != c_resp[7:1]);
            e_i    = (c_type == 2'd1) && (c_resp[45:40] != c_idx);
            e_e    = !c_resp[0];
            chk_ri = 1;
        end
        check("frame", 136'(frame_cap), 136'(ef));
        check_int("oe_bits", oe_bits, 48);
        check("resp", 136'(o_resp), 136'(e_resp));
        if (chk_ri) check("resp_index", 136'(o_resp_index), 136'(e_ri));
        check("timeout", 136'(o_timeout), 136'(e_t));
        check("crc_error", 136'(o_crc_error), 136'(e_c));
        check("index_error", 136'(o_index_error), 136'(e_i));
        check("end_bit_error", 136'(o_end_bit_error), 136'(e_e));
        check("busy_after_done", 136'(o_busy), 136'(0));
    endtask

    initial begin
        logic [135:0] r2, rr;
        logic [119:0] cid;
        logic [47:0]  w;
        logic [5:0]   ri;
        logic [1:0]   rt;
        logic [31:0]  ra;
        int b0, b1, k;

        rst_n = 1'b0; rise = 0; fall = 0; sd_cmd_in = 1'b1; sd_dat0 = 1'b1; start = 1'b0;
        resp_busy = 1'b0; idx = '0; arg = '0; rtype = '0; tmo = '0;
        repeat (5) tick();
        check("rst_oe", 136'(o_sd_cmd_oe), 136'(0));
        check("rst_cmd", 136'(o_sd_cmd), 136'(1));
        check("rst_busy", 136'(o_busy), 136'(0));
        check("rst_done", 136'(o_done), 136'(0));
        check("rst_resp", 136'(o_resp), 136'(0));
        check("rst_index", 136'(o_resp_index), 136'(0));
        check("rst_flags", 136'({o_timeout, o_crc_error, o_index_error, o_end_bit_error, o_busy_timeout}), 136'(0));
        rst_n = 1'b1;
        repeat (3) tick();

        // CMD0, no response
        run_cmd(6'd0, 32'd0, 2'd0, 16'd0, '0, 0, 0, 0, 0, 0);
        check("cmd0_frame_const", 136'(frame_cap), 136'(48'h400000000095));
        check_int("cmd0_ncc_rises", rises_low, 8);
        check_model(6'd0, 32'd0, 2'd0, '0, 0);

        // CMD8 with R7 reply
        run_cmd(6'd8, 32'h1AA, 2'd1, 16'd0, 136'(48'h08000001AA13), 48, 3, 0, 0, 0);
        check("cmd8_frame_const", 136'(frame_cap), 136'(48'h48000001AA87));
        check("cmd8_resp_const", 136'(o_resp), 136'(32'h000001AA));
        check_model(6'd8, 32'h1AA, 2'd1, 136'(48'h08000001AA13), 48);
        repeat (40) tick();
        check("hold_resp", 136'(o_resp), 136'(32'h000001AA));
        check("hold_index", 136'(o_resp_index), 136'(8));

        // Response timeouts: programmed and default
        run_cmd(6'd8, 32'h1AA, 2'd1, 16'd16, '0, 0, 0, 0, 0, 0);
        check_int("tmo16_rises", rises_at_tmo, 16);
        check_int("tmo16_done_rises", rises_low, 24);
        check_model(6'd8, 32'h1AA, 2'd1, '0, 0);
        run_cmd(6'd8, 32'h1AA, 2'd1, 16'd0, '0, 0, 0, 0, 0, 0);
        check_int("tmo_default_rises", rises_at_tmo, 64);
        check("tmo_default_flag", 136'(o_timeout), 136'(1));

        // CMD2 R2: good, one CID bit flipped, end bit 0
        cid = {$urandom(), $urandom(), $urandom(), $urandom()};
        r2  = {2'b00, 6'h3F, cid, crc7_div(136'(cid), 120), 1'b1};
        run_cmd(6'd2, 32'd0, 2'd2, 16'd0, r2, 136, 4, 0, 0, 0);
        check_model(6'd2, 32'd0, 2'd2, r2, 136);
        rr = r2; rr[70] = ~rr[70];
        run_cmd(6'd2, 32'd0, 2'd2, 16'd0, rr, 136, 4, 0, 0, 0);
        check("r2_flip_crc_error", 136'(o_crc_error), 136'(1));
        check_model(6'd2, 32'd0, 2'd2, rr, 136);
        rr = r2; rr[0] = 1'b0;
        run_cmd(6'd2, 32'd0, 2'd2, 16'd0, rr, 136, 4, 0, 0, 0);
        check("r2_end_bit_error", 136'(o_end_bit_error), 136'(1));

        // CMD41 R3 with CRC field all ones, as type 3 then type 1
        run_cmd(6'd41, 32'h40FF8000, 2'd3, 16'd0, 136'(48'h3F80FF8000FF), 48, 2, 0, 0, 0);
        check("r3_resp", 136'(o_resp), 136'(32'h80FF8000));
        check("r3_crc_error", 136'(o_crc_error), 136'(0));
        run_cmd(6'd41, 32'h40FF8000, 2'd1, 16'd0, 136'(48'h3F80FF8000FF), 48, 2, 0, 0, 0);
        check("r3_as_r1_index_error", 136'(o_index_error), 136'(1));
        check("r3_as_r1_crc_error", 136'(o_crc_error), 136'(1));

        // Start pulse mid-SEND is ignored
        run_cmd(6'd17, 32'h12345678, 2'd0, 16'd0, '0, 0, 0, 20, 0, 0);
        check_model(6'd17, 32'h12345678, 2'd0, '0, 0);

        // Reset mid-RECV, then a normal command
        run_cmd(6'd2, 32'd0, 2'd2, 16'd0, r2, 136, 4, 0, 60, 0);
        repeat (3) tick();
        run_cmd(6'd8, 32'h1AA, 2'd1, 16'd0, 136'(48'h08000001AA13), 48, 3, 0, 0, 0);
        check_model(6'd8, 32'h1AA, 2'd1, 136'(48'h08000001AA13), 48);

        // R1b busy wait on DAT0
        resp_busy = 1'b1;
        run_cmd(6'd7, 32'h00010000, 2'd1, 16'd0, 136'(48'h08000001AA13), 48, 3, 0, 0, 0);
        b0 = done_cyc;
        run_cmd(6'd7, 32'h00010000, 2'd1, 16'd0, 136'(48'h08000001AA13), 48, 3, 0, 0, 100);
        b1 = done_cyc;
        resp_busy = 1'b0;
`ifdef SD_CMD_BUSY_EN
        check_int("busy_delay_in_range", int'((b1 - b0 >= 92) && (b1 - b0 <= 108)), 1);
`else
        check_int("busy_ignored", b1, b0);
`endif
        check("busy_timeout_flag", 136'(o_busy_timeout), 136'(0));

        // Randomized commands against the model
        for (int n = 0; n < 12; n++) begin
            rt = 2'($urandom_range(0, 3));
            ri = 6'($urandom_range(0, 63));
            ra = $urandom();
            k  = $urandom_range(0, 6);
            rr = '0;
            if (rt == 2'd2) begin
                cid = {$urandom(), $urandom(), $urandom(), $urandom()};
                rr  = {2'b00, 6'h3F, cid, crc7_div(136'(cid), 120), 1'b1};
                if ($urandom_range(0, 3) == 0) rr[8 + k] = ~rr[8 + k];
                if ($urandom_range(0, 4) == 0) rr[0] = 1'b0;
                run_cmd(ri, ra, rt, 16'd0, rr, 136, $urandom_range(2, 8), 0, 0, 0);
                check_model(ri, ra, rt, rr, 136);
            end else if (rt != 2'd0) begin
                w = {2'b00, (rt == 2'd3) ? 6'h3F : (($urandom_range(0, 3) == 0) ? ~ri : ri), $urandom(), 8'h01};
                w[7:1] = (rt == 2'd3) ? 7'h7F : crc7_div(136'(w[47:8]), 40);
                if ($urandom_range(0, 3) == 0) w[1 + k] = ~w[1 + k];
                if ($urandom_range(0, 4) == 0) w[0] = 1'b0;
                rr = 136'(w);
                run_cmd(ri, ra, rt, 16'd0, rr, 48, $urandom_range(2, 8), 0, 0, 0);
                check_model(ri, ra, rt, rr, 48);
            end else begin
                run_cmd(ri, ra, rt, 16'd0, rr, 0, 0, 0, 0, 0);
                check_model(ri, ra, rt, rr, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
